// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with ack-wait timeout and sticky trap.
// Strobes decode from state (ack/zero qualified in the same cycle); requests are held until ack and drop while rst_n is low.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        zero,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  ALUOp,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        retire,
  output logic        trap
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_JUMP, S_MEMRD, S_MEMWR, S_WB, S_TRAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [5:0]       opcode;
  logic             unused_imm;
  logic             is_r, is_lw, is_sw, is_beq, is_j, legal;
  logic [2:0]       alu_op_dec;
  logic             mem_ack, timeout_hit;

  assign opcode     = instruction[31:26];
  assign unused_imm = ^instruction[25:0];
  assign is_r       = (opcode == OP_R);
  assign is_lw      = (opcode == OP_LW);
  assign is_sw      = (opcode == OP_SW);
  assign is_beq     = (opcode == OP_BEQ);
  assign is_j       = (opcode == OP_J);

  always_comb begin
    alu_op_dec = 3'b000;
    legal      = 1'b1;
    case (opcode)
      OP_R:                   alu_op_dec = 3'b010;
      OP_LW, OP_SW, OP_ADDI:  alu_op_dec = 3'b000;
      OP_BEQ:                 alu_op_dec = 3'b001;
      OP_ANDI:                alu_op_dec = 3'b100;
      OP_ORI:                 alu_op_dec = 3'b101;
      OP_SLTI:                alu_op_dec = 3'b110;
      OP_J:                   alu_op_dec = 3'b000;
      default:                legal      = 1'b0;
    endcase
  end

  // Only the ack belonging to the current wait state counts; ack on the last allowed cycle wins over timeout.
  assign mem_ack     = (state == S_FETCH) ? imem_ack : dmem_ack;
  assign timeout_hit = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            case (state)
              S_FETCH: state <= S_DECODE;
              S_MEMRD: state <= S_WB;
              default: state <= S_FETCH;
            endcase
          end else if (timeout_hit) begin
            wait_cnt <= '0;
            state    <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          if (is_j)       state <= S_JUMP;
          else if (legal) state <= S_EXEC;
          else            state <= S_TRAP;
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (is_lw)       state <= S_MEMRD;
          else if (is_sw)  state <= S_MEMWR;
          else if (is_beq) state <= S_FETCH;
          else             state <= S_WB;
        end
        S_JUMP, S_WB: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        default: begin
          wait_cnt <= '0;
          state    <= S_TRAP;
        end
      endcase
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ALUOp      = 3'b000;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    retire     = 1'b0;
    trap       = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          imem_req  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = imem_ack;
          pc_write  = imem_ack;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = (is_r || is_beq) ? 2'b00 : 2'b10;
          ALUOp     = alu_op_dec;
          if (is_beq) begin
            pc_write = zero;
            pc_src   = 2'b01;
            retire   = 1'b1;
          end
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          retire   = 1'b1;
        end
        S_MEMRD: dmem_rd = 1'b1;
        S_MEMWR: begin
          dmem_wr = 1'b1;
          retire  = dmem_ack;
        end
        S_WB: begin
          reg_write  = 1'b1;
          retire     = 1'b1;
          mem_to_reg = is_lw;
          reg_dst    = is_r;
        end
        default: trap = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected cycle sequences are queued by the driver
// and consumed by an independent negedge monitor.
module tb_multicycle_control;
  localparam int TO = 4;

  typedef struct packed {
    logic       imem_req, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       dmem_rd, dmem_wr, reg_write, mem_to_reg, reg_dst, retire, trap;
  } outv_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, zero = 1'b0;
  logic        imem_req, ir_write, pc_write, alu_src_a, dmem_rd, dmem_wr;
  logic        reg_write, mem_to_reg, reg_dst, retire, trap;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_op;

  int checks = 0;
  int failures = 0;
  outv_t exp_q[$];
  string tag_q[$];

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .zero(zero),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(alu_op),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .retire(retire), .trap(trap)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100,
      6'b001100, 6'b001101, 6'b001010, 6'b000010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] aluop_of(input logic [5:0] op);
    case (op)
      6'b000000: return 3'b010;
      6'b000100: return 3'b001;
      6'b001100: return 3'b100;
      6'b001101: return 3'b101;
      6'b001010: return 3'b110;
      default:   return 3'b000;
    endcase
  endfunction

  // One clock: drive inputs just after the rising edge and queue what that cycle must show.
  task automatic cyc(input logic r, input logic ia, input logic da, input logic z,
                     input logic [31:0] ir, input outv_t e, input string tag);
    @(posedge clk);
    #1;
    rst_n = r; imem_ack = ia; dmem_ack = da; zero = z; instruction = ir;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic trap_then_reset();
    outv_t e;
    for (int k = 0; k < 3; k++) begin
      e = '0; e.trap = 1'b1;
      cyc(1'b1, rb(), rb(), rb(), $urandom, e, "trap_sticky");
    end
    cyc(1'b0, rb(), rb(), rb(), $urandom, '0, "reset");
  endtask

  task automatic run_instr(input logic [5:0] op, input int fd, input int md,
                           input logic z, input int rst_mem);
    outv_t e;
    logic [31:0] ir;
    logic r_type, lw, sw, beq;
    ir = {op, 26'($urandom)};
    r_type = (op == 6'b000000); lw = (op == 6'b100011);
    sw = (op == 6'b101011); beq = (op == 6'b000100);
    for (int i = 0; i <= fd; i++) begin
      if (i == TO) begin trap_then_reset(); return; end
      e = '0; e.imem_req = 1'b1; e.alu_src_b = 2'b01;
      if (i == fd) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      cyc(1'b1, i == fd, rb(), rb(), $urandom, e, "fetch");
    end
    e = '0; e.alu_src_b = 2'b11;
    cyc(1'b1, rb(), rb(), rb(), ir, e, "decode");
    if (!is_legal(op)) begin trap_then_reset(); return; end
    if (op == 6'b000010) begin
      e = '0; e.pc_write = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1;
      cyc(1'b1, rb(), rb(), rb(), ir, e, "jump");
      return;
    end
    e = '0; e.alu_src_a = 1'b1; e.alu_op = aluop_of(op);
    e.alu_src_b = (r_type || beq) ? 2'b00 : 2'b10;
    if (beq) begin e.pc_write = z; e.pc_src = 2'b01; e.retire = 1'b1; end
    cyc(1'b1, rb(), rb(), z, ir, e, "exec");
    if (beq) return;
    if (lw || sw) begin
      for (int i = 0; i <= md; i++) begin
        if (i == rst_mem) begin cyc(1'b0, rb(), 1'b1, rb(), ir, '0, "rst_mid_mem"); return; end
        if (i == TO) begin trap_then_reset(); return; end
        e = '0; e.dmem_rd = lw; e.dmem_wr = sw; e.retire = sw && (i == md);
        cyc(1'b1, rb(), i == md, rb(), ir, e, "mem");
      end
      if (sw) return;
    end
    e = '0; e.reg_write = 1'b1; e.retire = 1'b1; e.mem_to_reg = lw; e.reg_dst = r_type;
    cyc(1'b1, rb(), rb(), rb(), ir, e, "wb");
  endtask

  initial begin : monitor
    outv_t act, e;
    string tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tag = tag_q.pop_front();
        act = {imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
               dmem_rd, dmem_wr, reg_write, mem_to_reg, reg_dst, retire, trap};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s @%0t: got %05h expected %05h", tag, $time, act, e);
        end
      end
    end
  end

  initial begin : driver
    logic [5:0] ops [9];
    int n;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100,
            6'b001100, 6'b001101, 6'b001010, 6'b000010};
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "reset");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, "reset");
    run_instr(6'b000000, 0, 0, 1'b0, -1);
    run_instr(6'b100011, 0, 3, 1'b0, -1);
    run_instr(6'b000100, 0, 0, 1'b1, -1);
    run_instr(6'b000100, 1, 0, 1'b0, -1);
    run_instr(6'b111111, 0, 0, 1'b0, -1);
    run_instr(6'b001101, TO, 0, 1'b0, -1);
    run_instr(6'b001101, TO - 1, 0, 1'b0, -1);
    run_instr(6'b101011, 0, 5, 1'b0, 2);
    run_instr(6'b101011, 0, TO - 1, 1'b0, -1);
    run_instr(6'b100011, 0, TO, 1'b0, -1);
    run_instr(6'b000010, 2, 0, 1'b0, -1);
    for (int t = 0; t < 60; t++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 8)];
      run_instr(op, $urandom_range(0, TO), $urandom_range(0, TO), rb(),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TO - 1)) : -1);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
